// File: rtl/aq_axi_sdma64_pkg.sv
// Shared constants and packer state type for the SDMA 64-bit write-stream packer.
package aq_axi_sdma64_pkg;
    localparam logic [7:0] STRB_FULL = 8'hFF;
    localparam logic [7:0] STRB_HALF = 8'h0F;

    typedef enum logic {EMPTY, HALF} pack_state_e;
endpackage

// File: rtl/aq_axi_sdma64_wpack_oreg.sv
// Single-entry output register with valid/ready; valid and data come straight from flops.
module aq_axi_sdma64_wpack_oreg (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [63:0] push_data,
    input  logic [7:0]  push_strb,
    input  logic        push_last,
    input  logic        ready,
    output logic        valid,
    output logic [63:0] data,
    output logic [7:0]  strb,
    output logic        last,
    output logic        free
);
    assign free = ~valid | ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            strb  <= '0;
            last  <= 1'b0;
        end else if (push && free) begin
            valid <= 1'b1;
            data  <= push_data;
            strb  <= push_strb;
            last  <= push_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/aq_axi_sdma64_wpack.sv
// Packs 32-bit beats into 64-bit W_AXIS words with strobe/TLAST and frame sync.
// Define AQ_AXI_SDMA64_WPACK_FCHK_EN to enable the FRAME_LEN word counter/checker.
module aq_axi_sdma64_wpack
    import aq_axi_sdma64_pkg::*;
(
    input  logic        ACLK,
    input  logic        RST,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic        S_AXIS_TLAST,
    input  logic        S_AXIS_TUSER,
    output logic [63:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [7:0]  M_AXIS_TSTRB,
    output logic        M_AXIS_TLAST,
    output logic        FRAME_SYNC,
    input  logic [31:0] FRAME_LEN,
    input  logic        ERR_CLR,
    output logic        LEN_ERR
);
    pack_state_e state;
    logic [31:0] half_data;
    logic        half_sof, half_last;
    logic        free, accept;
    logic        push, in_last, plast, push_sof, trunc, err_set;
    logic [63:0] pdata;
    logic [7:0]  pstrb;

    // half_last marks a held beat that must go out alone as a final half word
    assign S_AXIS_TREADY = ~RST & ((state == EMPTY) | (~half_last & free));
    assign accept        = S_AXIS_TVALID & S_AXIS_TREADY;

    always_comb begin
        push     = 1'b0;
        pdata    = '0;
        pstrb    = '0;
        in_last  = 1'b0;
        push_sof = 1'b0;
        trunc    = 1'b0;
        if (accept) begin
            if (state == EMPTY) begin
                if (S_AXIS_TLAST && free && !S_AXIS_TUSER) begin
                    push    = 1'b1;
                    pdata   = {32'h0, S_AXIS_TDATA};
                    pstrb   = STRB_HALF;
                    in_last = 1'b1;
                end
            end else if (!S_AXIS_TUSER) begin
                push     = 1'b1;
                pdata    = {S_AXIS_TDATA, half_data};
                pstrb    = STRB_FULL;
                in_last  = S_AXIS_TLAST;
                push_sof = half_sof;
            end else begin
                push     = 1'b1;
                pdata    = {32'h0, half_data};
                pstrb    = STRB_HALF;
                in_last  = 1'b1;
                push_sof = half_sof;
                trunc    = 1'b1;
            end
        end else if (state == HALF && half_last && free) begin
            push     = 1'b1;
            pdata    = {32'h0, half_data};
            pstrb    = STRB_HALF;
            in_last  = 1'b1;
            push_sof = half_sof;
        end
    end

`ifdef AQ_AXI_SDMA64_WPACK_FCHK_EN
    logic [31:0] wcnt, idx;
    logic        chk_on, forced;

    assign chk_on  = FRAME_LEN != 32'd0;
    assign idx     = push_sof ? 32'd0 : wcnt;
    assign forced  = chk_on & ~trunc & (idx == FRAME_LEN - 32'd1);
    assign plast   = in_last | forced;
    assign err_set = trunc | (push & chk_on & ~trunc & (in_last != forced));

    always_ff @(posedge ACLK) begin
        if (RST)       wcnt <= '0;
        else if (push) wcnt <= plast ? 32'd0 : idx + 32'd1;
    end
`else
    logic unused_fchk;
    assign unused_fchk = ^{FRAME_LEN, push_sof};
    assign plast       = in_last;
    assign err_set     = trunc;
`endif

    always_ff @(posedge ACLK) begin
        if (RST) begin
            state      <= EMPTY;
            half_data  <= '0;
            half_sof   <= 1'b0;
            half_last  <= 1'b0;
            FRAME_SYNC <= 1'b0;
            LEN_ERR    <= 1'b0;
        end else begin
            FRAME_SYNC <= accept & S_AXIS_TUSER;
            LEN_ERR    <= err_set | (LEN_ERR & ~ERR_CLR);
            if (accept) begin
                case (state)
                    EMPTY: if (!S_AXIS_TLAST || !free || S_AXIS_TUSER) begin
                        // a lone TLAST beat that cannot go out now is deferred as a final half
                        state     <= HALF;
                        half_data <= S_AXIS_TDATA;
                        half_sof  <= S_AXIS_TUSER;
                        half_last <= S_AXIS_TLAST;
                    end
                    HALF: if (!S_AXIS_TUSER) begin
                        state <= EMPTY;
                    end else begin
                        half_data <= S_AXIS_TDATA;
                        half_sof  <= 1'b1;
                        half_last <= S_AXIS_TLAST;
                    end
                    default: state <= EMPTY;
                endcase
            end else if (state == HALF && half_last && free) begin
                state     <= EMPTY;
                half_last <= 1'b0;
            end
        end
    end

    aq_axi_sdma64_wpack_oreg u_oreg (
        .clk       (ACLK),
        .rst       (RST),
        .push      (push),
        .push_data (pdata),
        .push_strb (pstrb),
        .push_last (plast),
        .ready     (M_AXIS_TREADY),
        .valid     (M_AXIS_TVALID),
        .data      (M_AXIS_TDATA),
        .strb      (M_AXIS_TSTRB),
        .last      (M_AXIS_TLAST),
        .free      (free)
    );
endmodule

// File: tb/tb_aq_axi_sdma64_wpack.sv
// Directed table-driven bench for the 64-bit write-stream packer, plus stream sequences.
module tb_aq_axi_sdma64_wpack;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0, s_last = 1'b0, s_user = 1'b0;
    logic        s_ready;
    logic [63:0] m_data;
    logic        m_valid, m_last;
    logic        m_ready = 1'b1;
    logic [7:0]  m_strb;
    logic        fsync, len_err;
    logic [31:0] frame_len = '0;
    logic        err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aq_axi_sdma64_wpack dut (
        .ACLK(clk), .RST(rst),
        .S_AXIS_TDATA(s_data), .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s_ready),
        .S_AXIS_TLAST(s_last), .S_AXIS_TUSER(s_user),
        .M_AXIS_TDATA(m_data), .M_AXIS_TVALID(m_valid), .M_AXIS_TREADY(m_ready),
        .M_AXIS_TSTRB(m_strb), .M_AXIS_TLAST(m_last),
        .FRAME_SYNC(fsync), .FRAME_LEN(frame_len), .ERR_CLR(err_clr), .LEN_ERR(len_err)
    );

    typedef struct {
        logic        vld;
        logic [31:0] d;
        logic        usr, lst, mrdy, eclr;
        logic        srdy, mv;
        logic [63:0] md;
        logic [7:0]  ms;
        logic        ml, fs, err;
    } vec_t;

    vec_t tbl[$];
    logic [63:0] gd[$];
    logic [7:0]  gs[$];
    logic        gl[$];

    function automatic vec_t mk(logic vld, logic [31:0] d, logic usr, logic lst, logic eclr,
                                logic srdy, logic mv, logic [63:0] md, logic [7:0] ms,
                                logic ml, logic fs, logic err);
        vec_t r;
        r.vld = vld; r.d = d; r.usr = usr; r.lst = lst; r.mrdy = 1'b1; r.eclr = eclr;
        r.srdy = srdy; r.mv = mv; r.md = md; r.ms = ms; r.ml = ml; r.fs = fs; r.err = err;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_cycle(input logic eclr);
        @(negedge clk);
        s_valid = 1'b0; s_user = 1'b0; s_last = 1'b0; err_clr = eclr; m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // Feeds n beats base..base+n-1, optionally stalling M_AXIS_TREADY, capturing words.
    task automatic stream(input int n, input bit sof, input bit eof, input int st0,
                          input int stn, input logic [31:0] base);
        int i, idl;
        bit done, st, pst;
        logic pmv, acc, take;
        logic [63:0] pdat;
        i = 0; idl = 0; done = 0; pst = 0; pmv = 0; pdat = '0;
        gd.delete(); gs.delete(); gl.delete();
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            st = (c >= st0) && (c < st0 + stn);
            s_valid = (i < n);
            s_data  = base + i;
            s_user  = sof && (i == 0);
            s_last  = eof && (i == n - 1);
            m_ready = !st;
            #1;
            if (st && pst && pmv) begin
                chk("stall_valid", {63'd0, m_valid}, 64'd1);
                chk("stall_data", m_data, pdat);
            end
            if (st && c >= st0 + 2 && i < n) chk("stall_sready", {63'd0, s_ready}, 64'd0);
            acc  = s_valid & s_ready;
            take = m_valid & m_ready;
            if (take) begin
                gd.push_back(m_data); gs.push_back(m_strb); gl.push_back(m_last);
            end
            pmv = m_valid; pdat = m_data; pst = st;
            if (i >= n && !m_valid) idl++;
            @(posedge clk);
            if (acc) i++;
            if (i >= n && idl >= 3) done = 1;
        end
        if (!done) begin
            errors++;
            $display("FAIL stream_timeout actual=%0d required=%0d", i, n);
        end
        @(negedge clk);
        s_valid = 1'b0; s_user = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sready", {63'd0, s_ready}, 64'd0);
        chk("rst_mvalid", {63'd0, m_valid}, 64'd0);
        chk("rst_mdata",  m_data, 64'd0);
        chk("rst_mstrb",  {56'd0, m_strb}, 64'd0);
        chk("rst_mlast",  {63'd0, m_last}, 64'd0);
        chk("rst_fsync",  {63'd0, fsync}, 64'd0);
        chk("rst_lenerr", {63'd0, len_err}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // vld d usr lst eclr | srdy mv md ms ml fs err
        tbl.push_back(mk(1, 32'h11, 1, 0, 0, 1, 0, 64'h0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(1, 32'h22, 0, 0, 0, 1, 1, 64'h00000022_00000011, 8'hFF, 0, 0, 0));
        tbl.push_back(mk(1, 32'h33, 0, 0, 0, 1, 0, 64'h0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 32'h44, 0, 1, 0, 1, 1, 64'h00000044_00000033, 8'hFF, 1, 0, 0));
        tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1, 0, 64'h0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 32'hA,  1, 0, 0, 1, 0, 64'h0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(1, 32'hB,  0, 0, 0, 1, 1, 64'h0000000B_0000000A, 8'hFF, 0, 0, 0));
        tbl.push_back(mk(1, 32'hC,  0, 1, 0, 1, 1, 64'h00000000_0000000C, 8'h0F, 1, 0, 0));
        tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1, 0, 64'h0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 32'h55, 1, 0, 0, 1, 0, 64'h0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(1, 32'h66, 1, 0, 0, 1, 1, 64'h00000000_00000055, 8'h0F, 1, 1, 1));
        tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1, 0, 64'h0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(1, 32'h77, 0, 1, 0, 1, 1, 64'h00000077_00000066, 8'hFF, 1, 0, 1));
        tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1, 0, 64'h0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(1, 32'h88, 1, 0, 0, 1, 0, 64'h0, 8'h00, 0, 1, 1));
        tbl.push_back(mk(1, 32'h99, 1, 0, 1, 1, 1, 64'h00000000_00000088, 8'h0F, 1, 1, 1));
        tbl.push_back(mk(0, 32'h0,  0, 0, 1, 1, 0, 64'h0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 32'hAA, 0, 1, 0, 1, 1, 64'h000000AA_00000099, 8'hFF, 1, 0, 0));
        tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1, 0, 64'h0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 32'hB1, 1, 0, 0, 1, 0, 64'h0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(1, 32'hB2, 1, 1, 0, 1, 1, 64'h00000000_000000B1, 8'h0F, 1, 1, 1));
        tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0, 1, 64'h00000000_000000B2, 8'h0F, 1, 0, 1));
        tbl.push_back(mk(0, 32'h0,  0, 0, 1, 1, 0, 64'h0, 8'h00, 0, 0, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            s_valid = tbl[i].vld; s_data = tbl[i].d; s_user = tbl[i].usr;
            s_last = tbl[i].lst; m_ready = tbl[i].mrdy; err_clr = tbl[i].eclr;
            #1;
            chk($sformatf("row%0d_sready", i), {63'd0, s_ready}, {63'd0, tbl[i].srdy});
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_mvalid", i), {63'd0, m_valid}, {63'd0, tbl[i].mv});
            chk($sformatf("row%0d_fsync", i),  {63'd0, fsync},   {63'd0, tbl[i].fs});
            chk($sformatf("row%0d_lenerr", i), {63'd0, len_err}, {63'd0, tbl[i].err});
            if (tbl[i].mv) begin
                chk($sformatf("row%0d_mdata", i), m_data, tbl[i].md);
                chk($sformatf("row%0d_mstrb", i), {56'd0, m_strb}, {56'd0, tbl[i].ms});
                chk($sformatf("row%0d_mlast", i), {63'd0, m_last}, {63'd0, tbl[i].ml});
            end
        end
        @(negedge clk);
        s_valid = 1'b0; err_clr = 1'b0;

        // continuous beats with a 5-cycle output stall
        stream(12, 1, 1, 4, 5, 32'h100);
        chk("bp_count", 64'(gd.size()), 64'd6);
        for (int k = 0; k < 6 && k < gd.size(); k++) begin
            chk($sformatf("bp_word%0d", k), gd[k], {32'h101 + 32'(2 * k), 32'h100 + 32'(2 * k)});
            chk($sformatf("bp_strb%0d", k), {56'd0, gs[k]}, 64'hFF);
            chk($sformatf("bp_last%0d", k), {63'd0, gl[k]}, {63'd0, (k == 5)});
        end

        // reset with half held and output word pending
        @(negedge clk);
        m_ready = 1'b0; s_valid = 1'b1; s_data = 32'hC1; s_user = 1'b1; s_last = 1'b0;
        @(negedge clk);
        s_data = 32'hC2;
        @(negedge clk);
        s_data = 32'hC3; s_user = 1'b0;
        #1;
        chk("pre_rst_sready", {63'd0, s_ready}, 64'd0);
        chk("pre_rst_lenerr", {63'd0, len_err}, 64'd1);
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0;
        #1;
        chk("in_rst_sready", {63'd0, s_ready}, 64'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_mvalid", {63'd0, m_valid}, 64'd0);
        chk("mid_rst_mdata",  m_data, 64'd0);
        chk("mid_rst_mstrb",  {56'd0, m_strb}, 64'd0);
        chk("mid_rst_mlast",  {63'd0, m_last}, 64'd0);
        chk("mid_rst_fsync",  {63'd0, fsync}, 64'd0);
        chk("mid_rst_lenerr", {63'd0, len_err}, 64'd0);
        @(negedge clk);
        rst = 1'b0; m_ready = 1'b1;
        stream(2, 1, 1, 1000, 0, 32'hD1);
        chk("post_rst_count", 64'(gd.size()), 64'd1);
        if (gd.size() > 0) begin
            chk("post_rst_word", gd[0], 64'h000000D2_000000D1);
            chk("post_rst_last", {63'd0, gl[0]}, 64'd1);
        end

`ifdef AQ_AXI_SDMA64_WPACK_FCHK_EN
        frame_len = 32'd2;
        stream(6, 1, 0, 1000, 0, 32'h200);
        chk("fchk2_count", 64'(gd.size()), 64'd3);
        for (int k = 0; k < 3 && k < gd.size(); k++)
            chk($sformatf("fchk2_last%0d", k), {63'd0, gl[k]}, {63'd0, (k == 1)});
        chk("fchk2_lenerr", {63'd0, len_err}, 64'd1);
        idle_cycle(1'b1);
        chk("fchk_clr", {63'd0, len_err}, 64'd0);
        frame_len = 32'd3;
        stream(6, 1, 1, 1000, 0, 32'h300);
        chk("fchk3_count", 64'(gd.size()), 64'd3);
        for (int k = 0; k < 3 && k < gd.size(); k++)
            chk($sformatf("fchk3_last%0d", k), {63'd0, gl[k]}, {63'd0, (k == 2)});
        chk("fchk3_lenerr", {63'd0, len_err}, 64'd0);
        frame_len = 32'd0;
`endif

        idle_cycle(1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
